// File: rtl/rs_alu_queue_if.sv
// rtl/rs_alu_queue_if.sv - allocate, CDB-snoop and issue bundle for rs_alu_queue
// Ports (master = core side, slave = reservation station):
//   alloc_*  : one renamed instruction per cycle, alloc_valid/alloc_ready handshake
//   cdb_*    : CDB_CNT result broadcast channels, channel i at slice i
//   issue_*  : oldest ready instruction to the ALU, issue_valid/issue_ready handshake
interface rs_alu_queue_if #(
   parameter int CDB_CNT = 3,
   parameter int TAG_W   = 4,
   parameter int OP_W    = 6,
   parameter int XLEN    = 32,
   parameter int RA_W    = 5
);
   logic                      alloc_valid;
   logic                      alloc_ready;
   logic [OP_W-1:0]           alloc_op;
   logic [TAG_W-1:0]          alloc_tagx;
   logic [TAG_W-1:0]          alloc_tagy;
   logic [TAG_W-1:0]          alloc_tagw;
   logic [XLEN-1:0]           alloc_datax;
   logic [XLEN-1:0]           alloc_datay;
   logic [RA_W-1:0]           alloc_rd;

   logic [CDB_CNT-1:0]        cdb_valid;
   logic [CDB_CNT*TAG_W-1:0]  cdb_tag;
   logic [CDB_CNT*XLEN-1:0]   cdb_data;

   logic                      issue_valid;
   logic                      issue_ready;
   logic [OP_W-1:0]           issue_op;
   logic [XLEN-1:0]           issue_datax;
   logic [XLEN-1:0]           issue_datay;
   logic [TAG_W-1:0]          issue_tagw;
   logic [RA_W-1:0]           issue_rd;

   modport master (
      output alloc_valid, alloc_op, alloc_tagx, alloc_tagy, alloc_tagw,
             alloc_datax, alloc_datay, alloc_rd,
             cdb_valid, cdb_tag, cdb_data, issue_ready,
      input  alloc_ready, issue_valid, issue_op, issue_datax, issue_datay,
             issue_tagw, issue_rd
   );

   modport slave (
      input  alloc_valid, alloc_op, alloc_tagx, alloc_tagy, alloc_tagw,
             alloc_datax, alloc_datay, alloc_rd,
             cdb_valid, cdb_tag, cdb_data, issue_ready,
      output alloc_ready, issue_valid, issue_op, issue_datax, issue_datay,
             issue_tagw, issue_rd
   );
endinterface

// File: rtl/rs_alu_queue.sv
// rtl/rs_alu_queue.sv - collapsing age-ordered ALU reservation station
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   rdy      : global enable, 0 freezes all state
//   flush    : squash every entry at the next edge
//   bus      : rs_alu_queue_if slave (alloc, CDB snoop, issue)
//   count    : number of occupied entries
module rs_alu_queue #(
   parameter int ENTRIES = 4,
   parameter int CDB_CNT = 3,
   parameter int TAG_W   = 4,
   parameter int OP_W    = 6,
   parameter int XLEN    = 32,
   parameter int RA_W    = 5,
   localparam int CW     = $clog2(ENTRIES + 1),
   localparam int IW     = $clog2(ENTRIES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   input  logic          flush,
   rs_alu_queue_if.slave bus,
   output logic [CW-1:0] count
);

   typedef struct packed {
      logic             v;
      logic [OP_W-1:0]  op;
      logic [TAG_W-1:0] tx;
      logic [XLEN-1:0]  dx;
      logic [TAG_W-1:0] ty;
      logic [XLEN-1:0]  dy;
      logic [TAG_W-1:0] tw;
      logic [RA_W-1:0]  rd;
   } ent_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } opnd_t;

   ent_t q   [ENTRIES];
   ent_t n_q [ENTRIES];
   // Woken copy of the queue plus one always-empty slot on top, so the
   // collapse below can read index e+1 without a bounds special case.
   ent_t s_q [ENTRIES+1];

   logic [CDB_CNT-1:0] cdb_v;
   logic [TAG_W-1:0]   cdb_t [CDB_CNT];
   logic [XLEN-1:0]    cdb_d [CDB_CNT];

   logic [ENTRIES-1:0] ready;
   logic [IW-1:0]      sel;
   logic               any_ready;
   logic               issue_fire;
   logic               alloc_fire;
   logic [CW-1:0]      alloc_idx;
   logic [CW-1:0]      n_count;

   assign cdb_v = bus.cdb_valid;
   for (genvar i = 0; i < CDB_CNT; i++) begin : g_cdb
      assign cdb_t[i] = bus.cdb_tag[i*TAG_W +: TAG_W];
      assign cdb_d[i] = bus.cdb_data[i*XLEN +: XLEN];
   end

   // Scanning from the top channel down lets the lowest matching channel
   // overwrite last. A zero tag is already ready and is never replaced.
   function automatic opnd_t wake(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
      opnd_t r;
      r.tag  = t;
      r.data = d;
      for (int i = CDB_CNT - 1; i >= 0; i--) begin
         if (cdb_v[i] && (t != '0) && (cdb_t[i] == t)) begin
            r.tag  = '0;
            r.data = cdb_d[i];
         end
      end
      return r;
   endfunction

   // Oldest-first select: lowest index wins, again by scanning downward.
   always_comb begin
      sel       = '0;
      any_ready = 1'b0;
      for (int e = ENTRIES - 1; e >= 0; e--) begin
         ready[e] = q[e].v && (q[e].tx == '0) && (q[e].ty == '0);
         if (ready[e]) begin
            sel       = IW'(e);
            any_ready = 1'b1;
         end
      end
   end

   assign bus.issue_valid = any_ready & rdy;
   assign bus.issue_op    = q[sel].op;
   assign bus.issue_datax = q[sel].dx;
   assign bus.issue_datay = q[sel].dy;
   assign bus.issue_tagw  = q[sel].tw;
   assign bus.issue_rd    = q[sel].rd;

   assign bus.alloc_ready = (count < CW'(ENTRIES)) & rdy;

   assign issue_fire = bus.issue_valid & bus.issue_ready;
   assign alloc_fire = bus.alloc_valid & bus.alloc_ready;
   // The new entry lands just above the surviving entries after the collapse.
   assign alloc_idx  = count - CW'(issue_fire);
   assign n_count    = flush ? '0 : (count + CW'(alloc_fire) - CW'(issue_fire));

   always_comb begin
      opnd_t ox;
      opnd_t oy;
      for (int e = 0; e < ENTRIES; e++) begin
         ox      = wake(q[e].tx, q[e].dx);
         oy      = wake(q[e].ty, q[e].dy);
         s_q[e]    = q[e];
         s_q[e].tx = ox.tag;
         s_q[e].dx = ox.data;
         s_q[e].ty = oy.tag;
         s_q[e].dy = oy.data;
      end
      s_q[ENTRIES] = '0;

      ox = wake(bus.alloc_tagx, bus.alloc_datax);
      oy = wake(bus.alloc_tagy, bus.alloc_datay);

      for (int e = 0; e < ENTRIES; e++) begin
         if (issue_fire && (IW'(e) >= sel)) begin
            n_q[e] = s_q[e+1];
         end else begin
            n_q[e] = s_q[e];
         end
         if (alloc_fire && (CW'(e) == alloc_idx)) begin
            n_q[e].v  = 1'b1;
            n_q[e].op = bus.alloc_op;
            n_q[e].tx = ox.tag;
            n_q[e].dx = ox.data;
            n_q[e].ty = oy.tag;
            n_q[e].dy = oy.data;
            n_q[e].tw = bus.alloc_tagw;
            n_q[e].rd = bus.alloc_rd;
         end
         if (flush) begin
            n_q[e].v = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         for (int e = 0; e < ENTRIES; e++) begin
            q[e] <= '0;
         end
      end else if (rdy) begin
         count <= n_count;
         for (int e = 0; e < ENTRIES; e++) begin
            q[e] <= n_q[e];
         end
      end
   end

endmodule

// File: tb/tb_rs_alu_queue.sv
// tb/tb_rs_alu_queue.sv - scoreboard bench for rs_alu_queue
module tb_rs_alu_queue;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] dx;
      logic [31:0] dy;
      logic [3:0]  tw;
      logic [4:0]  rd;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rdy;
   logic       flush;
   logic [2:0] count;

   int   n_checks = 0;
   int   n_fail   = 0;
   rec_t exp_q[$];
   rec_t mon_act;
   rec_t mon_exp;

   rs_alu_queue_if bus ();

   rs_alu_queue dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   // Monitor: every accepted issue is popped against the scoreboard.
   always @(negedge clk) begin
      if (!rst && bus.issue_valid && bus.issue_ready) begin
         mon_act = '{bus.issue_op, bus.issue_datax, bus.issue_datay, bus.issue_tagw, bus.issue_rd};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got op=%h dx=%h dy=%h tw=%h rd=%h, required no issue",
                     mon_act.op, mon_act.dx, mon_act.dy, mon_act.tw, mon_act.rd);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               n_fail++;
               $display("FAIL issue_rec: got op=%h dx=%h dy=%h tw=%h rd=%h, required op=%h dx=%h dy=%h tw=%h rd=%h",
                        mon_act.op, mon_act.dx, mon_act.dy, mon_act.tw, mon_act.rd,
                        mon_exp.op, mon_exp.dx, mon_exp.dy, mon_exp.tw, mon_exp.rd);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.alloc_valid = 1'b0;
      bus.alloc_op    = '0;
      bus.alloc_tagx  = '0;
      bus.alloc_tagy  = '0;
      bus.alloc_tagw  = '0;
      bus.alloc_datax = '0;
      bus.alloc_datay = '0;
      bus.alloc_rd    = '0;
      bus.cdb_valid   = '0;
      bus.cdb_tag     = '0;
      bus.cdb_data    = '0;
      bus.issue_ready = 1'b0;
      flush           = 1'b0;
   endtask

   task automatic put(input logic [5:0] o, input logic [3:0] tx, input logic [3:0] ty,
                      input logic [31:0] dx, input logic [31:0] dy,
                      input logic [3:0] tw, input logic [4:0] rd);
      bus.alloc_valid = 1'b1;
      bus.alloc_op    = o;
      bus.alloc_tagx  = tx;
      bus.alloc_tagy  = ty;
      bus.alloc_datax = dx;
      bus.alloc_datay = dy;
      bus.alloc_tagw  = tw;
      bus.alloc_rd    = rd;
   endtask

   task automatic expect_issue(input logic [5:0] o, input logic [31:0] dx, input logic [31:0] dy,
                               input logic [3:0] tw, input logic [4:0] rd);
      exp_q.push_back('{o, dx, dy, tw, rd});
   endtask

   task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] data);
      bus.cdb_valid[ch]       = 1'b1;
      bus.cdb_tag[ch*4 +: 4]  = tag;
      bus.cdb_data[ch*32 +: 32] = data;
   endtask

   task automatic drain(input int max);
      int n = 0;
      bus.issue_ready = 1'b1;
      mid();
      while (count != 0 && n < max) begin
         cyc();
         mid();
         n++;
      end
      chk("drain_empty", 32'(count), 0);
      cyc();
      bus.issue_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      mid();
      chk("rst_count", 32'(count), 0);
      chk("rst_issue_valid", 32'(bus.issue_valid), 0);
      chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
      chk("rst_issue_datax", bus.issue_datax, 0);
      chk("rst_issue_rd", 32'(bus.issue_rd), 0);
      cyc();

      // Single ready alloc, issued one cycle later
      expect_issue(6'h01, 32'd5, 32'd7, 4'd3, 5'd9);
      put(6'h01, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3, 5'd9);
      cyc();
      idle();
      bus.issue_ready = 1'b1;
      mid();
      chk("t1_valid", 32'(bus.issue_valid), 1);
      chk("t1_count", 32'(count), 1);
      chk("t1_datax", bus.issue_datax, 32'd5);
      chk("t1_datay", bus.issue_datay, 32'd7);
      chk("t1_tagw", 32'(bus.issue_tagw), 3);
      chk("t1_rd", 32'(bus.issue_rd), 9);
      cyc();
      bus.issue_ready = 1'b0;
      mid();
      chk("t1_count_after", 32'(count), 0);
      chk("t1_valid_after", 32'(bus.issue_valid), 0);
      cyc();

      // Oldest-ready select and wakeup; lowest CDB channel wins
      expect_issue(6'h02, 32'h55, 32'h22, 4'd4, 5'd1);
      put(6'h02, 4'd2, 4'd0, 32'h11, 32'h22, 4'd4, 5'd1);
      cyc();
      expect_issue(6'h03, 32'h33, 32'h44, 4'd5, 5'd2);
      put(6'h03, 4'd0, 4'd0, 32'h33, 32'h44, 4'd5, 5'd2);
      cyc();
      expect_issue(6'h04, 32'h66, 32'h77, 4'd6, 5'd3);
      put(6'h04, 4'd0, 4'd0, 32'h66, 32'h77, 4'd6, 5'd3);
      cyc();
      idle();
      mid();
      chk("t2_count", 32'(count), 3);
      chk("t2_b_rd", 32'(bus.issue_rd), 2);
      chk("t2_b_datax", bus.issue_datax, 32'h33);
      cyc();
      cdb(1, 4'd2, 32'h55);
      cdb(2, 4'd2, 32'h99);
      mid();
      chk("t2_b_still_rd", 32'(bus.issue_rd), 2);
      cyc();
      idle();
      mid();
      chk("t2_a_rd", 32'(bus.issue_rd), 1);
      chk("t2_a_datax", bus.issue_datax, 32'h55);
      cyc();
      drain(10);

      // Fill to full, ignored alloc, broadcast wakes all four
      for (int k = 0; k < 4; k++) begin
         expect_issue(6'(6'h10 + k), 32'hAA, (k % 2 == 1) ? 32'hAA : 32'(32'h100 + k),
                      4'(8 + k), 5'(16 + k));
         put(6'(6'h10 + k), 4'd5, (k % 2 == 1) ? 4'd5 : 4'd0, 32'(k), 32'(32'h100 + k),
             4'(8 + k), 5'(16 + k));
         cyc();
      end
      idle();
      mid();
      chk("t3_count_full", 32'(count), 4);
      chk("t3_alloc_ready_full", 32'(bus.alloc_ready), 0);
      chk("t3_valid_waiting", 32'(bus.issue_valid), 0);
      cyc();
      put(6'h3F, 4'd0, 4'd0, 32'hDEAD, 32'hBEEF, 4'd1, 5'd31);
      mid();
      chk("t3_alloc_ready_held", 32'(bus.alloc_ready), 0);
      cyc();
      idle();
      cdb(0, 4'd5, 32'hAA);
      mid();
      chk("t3_count_ignored", 32'(count), 4);
      chk("t3_valid_pre_wake", 32'(bus.issue_valid), 0);
      cyc();
      idle();
      bus.issue_ready = 1'b1;
      mid();
      chk("t3_valid_woken", 32'(bus.issue_valid), 1);
      chk("t3_alloc_ready_still0", 32'(bus.alloc_ready), 0);
      chk("t3_first_rd", 32'(bus.issue_rd), 16);
      cyc();
      mid();
      chk("t3_alloc_ready_back", 32'(bus.alloc_ready), 1);
      chk("t3_count_3", 32'(count), 3);
      cyc();
      drain(10);

      // Allocation-time bypass; tag 0 on the CDB wakes nothing
      expect_issue(6'h20, 32'hABC, 32'h1234, 4'd7, 5'd5);
      put(6'h20, 4'd0, 4'd6, 32'hABC, 32'hDEAD, 4'd7, 5'd5);
      cdb(1, 4'd0, 32'hBAD);
      cdb(2, 4'd6, 32'h1234);
      cyc();
      idle();
      mid();
      chk("t4_valid", 32'(bus.issue_valid), 1);
      chk("t4_datay", bus.issue_datay, 32'h1234);
      chk("t4_datax", bus.issue_datax, 32'hABC);
      cyc();
      drain(10);

      // Flush with same-cycle alloc
      for (int k = 0; k < 3; k++) begin
         put(6'(6'h21 + k), 4'd0, 4'd0, 32'(k), 32'(k), 4'd2, 5'(k));
         cyc();
      end
      put(6'h2F, 4'd0, 4'd0, 32'h1, 32'h2, 4'd3, 5'd7);
      flush = 1'b1;
      mid();
      chk("t5_valid_unmasked", 32'(bus.issue_valid), 1);
      chk("t5_alloc_ready_unmasked", 32'(bus.alloc_ready), 1);
      chk("t5_count_pre", 32'(count), 3);
      cyc();
      idle();
      mid();
      chk("t5_count_flushed", 32'(count), 0);
      chk("t5_valid_flushed", 32'(bus.issue_valid), 0);
      cyc();

      // rdy=0 freeze, then asynchronous reset between edges
      put(6'h24, 4'd0, 4'd0, 32'h24, 32'h24, 4'd1, 5'd20);
      cyc();
      put(6'h25, 4'd0, 4'd0, 32'h25, 32'h25, 4'd1, 5'd21);
      cyc();
      idle();
      rdy = 1'b0;
      put(6'h26, 4'd0, 4'd0, 32'h26, 32'h26, 4'd1, 5'd22);
      bus.issue_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("t6_frozen_valid", 32'(bus.issue_valid), 0);
         chk("t6_frozen_alloc_ready", 32'(bus.alloc_ready), 0);
         chk("t6_frozen_count", 32'(count), 2);
         cyc();
      end
      rdy = 1'b1;
      idle();
      mid();
      chk("t6_count_kept", 32'(count), 2);
      chk("t6_valid_back", 32'(bus.issue_valid), 1);
      chk("t6_rd_kept", 32'(bus.issue_rd), 20);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_count", 32'(count), 0);
      chk("t6_async_valid", 32'(bus.issue_valid), 0);
      #1 rst = 1'b0;
      cyc();
      mid();
      chk("t6_post_rst_count", 32'(count), 0);
      chk("t6_post_rst_alloc_ready", 32'(bus.alloc_ready), 1);
      cyc();

      // Alloc + issue + wakeup in one edge
      expect_issue(6'h30, 32'd1, 32'd2, 4'd1, 5'd10);
      put(6'h30, 4'd0, 4'd0, 32'd1, 32'd2, 4'd1, 5'd10);
      cyc();
      expect_issue(6'h31, 32'h77, 32'd4, 4'd2, 5'd11);
      put(6'h31, 4'd3, 4'd0, 32'd0, 32'd4, 4'd2, 5'd11);
      cyc();
      expect_issue(6'h32, 32'h77, 32'h77, 4'd3, 5'd12);
      put(6'h32, 4'd3, 4'd3, 32'd0, 32'd0, 4'd3, 5'd12);
      cdb(0, 4'd3, 32'h77);
      bus.issue_ready = 1'b1;
      mid();
      chk("t7_count_pre", 32'(count), 2);
      cyc();
      idle();
      mid();
      chk("t7_count_same", 32'(count), 2);
      chk("t7_valid", 32'(bus.issue_valid), 1);
      chk("t7_rd", 32'(bus.issue_rd), 11);
      chk("t7_datax", bus.issue_datax, 32'h77);
      cyc();
      drain(10);

      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/rs_alu_queue.md
# rs_alu_queue

Parametrised ALU reservation station for the out-of-order core: a collapsing, age-ordered queue of `ENTRIES` slots that accepts one renamed instruction per cycle from the allocator, snoops `CDB_CNT` result broadcast channels to resolve operand tags, and issues the oldest fully-ready instruction to a single ALU through a valid/ready handshake. It replaces fixed per-ALU slots with a configurable depth, adds oldest-first selection, allocation-time CDB bypass, a full indicator and a squash input.

## Interface
- `ENTRIES`, 4: queue depth, ≥2.
- `CDB_CNT`, 3: number of broadcast channels snooped.
- `TAG_W`, 4: rename tag width; tag value 0 = UNLOCKED (operand ready).
- `OP_W`, 6: decoded op width.
- `XLEN`, 32: data width.
- `RA_W`, 5: architectural destination register address width.

- `clk` in 1: the one clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rdy` in 1: global enable; 0 freezes all state.
- `flush` in 1: squash all entries.
- `alloc_valid` in 1: allocator presents an instruction.
- `alloc_ready` out 1: a free slot exists.
- `alloc_op` in OP_W; `alloc_tagx`, `alloc_tagy`, `alloc_tagw` in TAG_W; `alloc_datax`, `alloc_datay` in XLEN; `alloc_rd` in RA_W.
- `cdb_valid` in CDB_CNT: per-channel broadcast valid.
- `cdb_tag` in CDB_CNT*TAG_W, `cdb_data` in CDB_CNT*XLEN: channel i at slice i.
- `issue_valid` out 1: oldest ready entry presented.
- `issue_ready` in 1: ALU accepts.
- `issue_op` out OP_W; `issue_datax`, `issue_datay` out XLEN; `issue_tagw` out TAG_W; `issue_rd` out RA_W.
- `count` out clog2(ENTRIES+1): occupied entries.

## Operation
- Storage: per entry valid, op, tagx/datax, tagy/datay, tagw, rd. Valid entries are packed at indices 0..count-1; index 0 is oldest.
- Ready(e) = valid && tagx==0 && tagy==0.
- Issue select: the lowest-index ready entry drives the `issue_*` outputs combinationally from registers. `issue_valid` = any ready entry && rdy. When there is no ready entry, the data outputs are don't-care.
- Issue fire = `issue_valid && issue_ready`. The selected entry is removed, and every entry above it shifts down one index in the same edge. Order is preserved.
- Allocation fire = `alloc_valid && alloc_ready`. The new entry is written at index count, or count-1 if issue also fires that cycle. `alloc_ready` = (count < ENTRIES) && rdy. It does not depend on `issue_ready`, so there is no combinational path.
- alloc_valid with alloc_ready=0 is ignored; the allocator must hold.
- Wakeup:
  - Every valid entry operand with a nonzero tag compares against each channel with `cdb_valid[i]`. On a match, its tag becomes 0 and its data becomes `cdb_data[i]`.
  - The lowest channel index wins if several channels match.
  - Wakeup applies to entries that shift in the same edge; the shifted entry carries the updated value.
- Allocation bypass: the incoming tagx/tagy are compared against the CDB in the same cycle using the same rule, so a result broadcast in the allocation cycle is not lost.
- tagw and rd pass through unchanged. Tag 0 on the CDB never wakes anything.
- Flush: all valid bits clear at the next edge; count becomes 0. Flush has priority over alloc, issue and wakeup. `issue_valid`/`alloc_ready` are not masked during the flush cycle, but issue and alloc do not take effect.
- rdy=0: no state change (no alloc, issue, wakeup or flush). `alloc_ready`=0 and `issue_valid`=0. CDB traffic in those cycles is not captured; the core guarantees the CDB is idle while rdy=0.

## Timing
- Reset (async, immediate):
  - all entries invalid, all tags 0, data 0; count=0.
  - `issue_valid`=0; `alloc_ready`=1 once rst deasserts and rdy=1.
  - `issue_*` data outputs read 0.
- Allocation with both tags 0 at edge t → `issue_valid`=1 during cycle t+1. Minimum alloc-to-issue latency is 1 cycle.
- A CDB match at edge t (entry or bypass) → the entry is ready in cycle t+1.
- Issue fire at edge t → the next-oldest ready entry is presented in cycle t+1.
- Full (count=ENTRIES) and issue fires at edge t → `alloc_ready`=1 in cycle t+1. No same-cycle reuse of the freed slot.
- Simultaneous alloc + issue + wakeup in one edge: all three apply. count is unchanged.
- rst asserted mid-operation clears state regardless of clk and rdy.

## Test plan
- Reset, then alloc op=ADD, tagx=tagy=0, datax=5, datay=7, tagw=3, rd=9 → next cycle issue_valid=1 with datax=5, datay=7, tagw=3, rd=9, count=1; issue_ready=1 → count=0 and issue_valid=0 after the edge.
- Alloc A(tagx=2), then B(ready), then C(ready); hold issue_ready=0 → B is presented (oldest ready). CDB ch1 tag=2 data=0x55 → A is presented next cycle with datax=0x55; order of issue is A, B, C.
- Fill 4 entries, all waiting on tag 5 → count=4, alloc_ready=0, an alloc_valid pulse is ignored. CDB ch0 tag=5 data=0xAA → all four issue in order with data 0xAA; alloc_ready returns the cycle after the first issue.
- Alloc with tagy=6 in the same cycle as CDB ch2 tag=6 data=0x1234 → the entry is ready the next cycle with datay=0x1234.
- Three entries plus same-cycle alloc and flush=1 → count=0 and issue_valid=0 next cycle; the allocated entry is discarded.
- rdy=0 for 3 cycles with pending ready entries → issue_valid=0, alloc_ready=0, and count/contents are unchanged. Async rst pulse between clock edges → count=0 immediately.
